// File: rtl/seg_disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display path.
//   NUM_DIGITS      number of scanned digits
//   SEG_BLANK_CODE  nibble the BCD_to_7seg decoder renders as all segments off
//   DIGIT_OFF       active-low digit strobe value with every digit disabled
//   digit_onehot_n  active-low one-hot strobe for a 2-bit digit index
package seg_disp_pkg;

    localparam int unsigned NUM_DIGITS     = 4;
    localparam logic [3:0]  SEG_BLANK_CODE = 4'hF;
    localparam logic [3:0]  DIGIT_OFF      = 4'b1111;

    function automatic logic [3:0] digit_onehot_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_refresh_tick.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (count returns to 0)
//   tick   high for one cycle while the count equals DIV-1; first tick
//          occurs DIV cycles after reset release
module seg_refresh_tick #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        tick    = (count_q == LAST);
        count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes a 4-digit packed BCD word onto a 4-digit display that is
// driven through BCD_to_7seg. One digit is presented per refresh tick.
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   load_valid   new display word offered
//   load_data    packed BCD, [3:0] = digit 0 ... [15:12] = digit 3
//   load_ready   shadow register free; word accepted on valid & ready
//   lz_en        runtime enable for leading-zero blanking
//   disp_en      0 = all digit strobes off from the next tick
//   bcd_out      nibble to decoder, 4'hF = blank
//   digit_sel    active-low digit strobe
//   frame_done   one-cycle pulse when digit 3 is presented
//   bcd_err      last accepted word held a nibble > 9
module seg_scan_mux
    import seg_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic        lz_en,
    input  logic        disp_en,
    output logic [3:0]  bcd_out,
    output logic [3:0]  digit_sel,
    output logic        frame_done,
    output logic        bcd_err
);

    logic tick;

    seg_refresh_tick #(
        .DIV (REFRESH_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    logic [1:0]  idx_q,        idx_d;
    logic [15:0] shadow_q,     shadow_d;
    logic [15:0] display_q,    display_d;
    logic        pending_q,    pending_d;
    logic [3:0]  bcd_out_q,    bcd_out_d;
    logic [3:0]  digit_sel_q,  digit_sel_d;
    logic        frame_done_q, frame_done_d;
    logic        bcd_err_q,    bcd_err_d;

    logic [3:0]  blank_vec;
    logic        zeros_above;
    logic        load_bad;
    logic        accept;
    logic        boundary;
    logic [3:0]  cur_nib;

    // Per-digit blanking from the display register. Scan from digit 3 down so
    // zeros_above tracks "this digit and all higher digits are zero".
    always_comb begin
        blank_vec   = '0;
        zeros_above = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            int unsigned i;
            logic [3:0]  nib;
            i           = NUM_DIGITS - 1 - k;
            nib         = display_q[4*i +: 4];
            zeros_above = zeros_above & (nib == 4'd0);
            blank_vec[i] = (nib > 4'd9)
                         | (LZ_BLANK & lz_en & (i != 0) & zeros_above);
        end
    end

    always_comb begin
        load_bad = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            load_bad = load_bad | (load_data[4*i +: 4] > 4'd9);
        end
    end

    always_comb begin
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        display_d    = display_q;
        pending_d    = pending_q;
        bcd_out_d    = bcd_out_q;
        digit_sel_d  = digit_sel_q;
        frame_done_d = 1'b0;
        bcd_err_d    = bcd_err_q;

        accept   = load_valid & ~pending_q;
        boundary = tick & (idx_q == 2'd3);
        cur_nib  = display_q[4*idx_q +: 4];

        if (tick) begin
            digit_sel_d  = disp_en ? digit_onehot_n(idx_q) : DIGIT_OFF;
            bcd_out_d    = blank_vec[idx_q] ? SEG_BLANK_CODE : cur_nib;
            idx_d        = idx_q + 1'b1;
            frame_done_d = boundary;
        end

        // Copy and accept are mutually exclusive (pending vs ~pending), so a
        // word accepted on a boundary waits in shadow for the next boundary.
        if (boundary && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end

        if (accept) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
            bcd_err_d = load_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            bcd_out_q    <= SEG_BLANK_CODE;
            digit_sel_q  <= DIGIT_OFF;
            frame_done_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            bcd_out_q    <= bcd_out_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
            bcd_err_q    <= bcd_err_d;
        end
    end

    assign load_ready = ~pending_q;
    assign bcd_out    = bcd_out_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;
    assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with REFRESH_DIV = 4.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        lz_en;
    logic        disp_en;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        frame_done;
    logic        bcd_err;

    int total = 0;
    int bad   = 0;
    int cyc;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .REFRESH_DIV (4),
        .LZ_BLANK    (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .lz_en      (lz_en),
        .disp_en    (disp_en),
        .bcd_out    (bcd_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done),
        .bcd_err    (bcd_err)
    );

    // Rising edges since reset release; slot edges are multiples of 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [15:0] word;
        logic        lz;
        logic [15:0] exp_nibs;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];
    logic [3:0] sel_tab[4];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_slot();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((cyc % 4) != 0 && n < 8);
    endtask

    function automatic int cur_digit();
        return ((cyc / 4) - 1) % 4;
    endfunction

    task automatic sync_d0();
        next_slot();
        for (int k = 0; k < 4 && cur_digit() != 0; k++) next_slot();
    endtask

    task automatic run_frame(input string name, input logic [15:0] exp);
        sync_d0();
        for (int d = 0; d < 4; d++) begin
            if (d > 0) next_slot();
            chk({name, "_sel"}, 16'(digit_sel), 16'(sel_tab[d]));
            chk({name, "_bcd"}, 16'(bcd_out), 16'(exp[4*d +: 4]));
            chk({name, "_fd"},  16'(frame_done), 16'(d == 3));
        end
    endtask

    task automatic load_word(input logic [15:0] w, output int acc_cyc);
        int n = 0;
        acc_cyc    = -1;
        load_data  = w;
        load_valid = 1'b1;
        while (!load_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!load_ready) begin
            total++;
            bad++;
            $display("FAIL load_timeout: got load_ready=0 expected 1 within 40 cycles");
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            chk("ready_after_accept", 16'(load_ready), 16'h0);
        end
        load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;

        sel_tab[0] = 4'b1110;
        sel_tab[1] = 4'b1101;
        sel_tab[2] = 4'b1011;
        sel_tab[3] = 4'b0111;

        vecs[0] = '{16'h1234, 1'b0, 16'h1234, 1'b0};
        vecs[1] = '{16'h0050, 1'b1, 16'hFF50, 1'b0};
        vecs[2] = '{16'h0000, 1'b1, 16'hFFF0, 1'b0};
        vecs[3] = '{16'h0100, 1'b1, 16'hF100, 1'b0};
        vecs[4] = '{16'h12A4, 1'b0, 16'h12F4, 1'b1};
        vecs[5] = '{16'h0009, 1'b0, 16'h0009, 1'b0};

        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        lz_en      = 1'b0;
        disp_en    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd",   16'(bcd_out),    16'hF);
        chk("rst_sel",   16'(digit_sel),  16'hF);
        chk("rst_fd",    16'(frame_done), 16'h0);
        chk("rst_err",   16'(bcd_err),    16'h0);
        chk("rst_ready", 16'(load_ready), 16'h1);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk("pre_tick_sel", 16'(digit_sel), 16'hF);
            chk("pre_tick_bcd", 16'(bcd_out),   16'hF);
        end

        // Two full frames of the all-zero display straight out of reset.
        for (int s = 0; s < 8; s++) begin
            next_slot();
            chk("scan_sel", 16'(digit_sel),  16'(sel_tab[s % 4]));
            chk("scan_fd",  16'(frame_done), 16'((s % 4) == 3));
            chk("scan_bcd", 16'(bcd_out),    16'h0);
        end

        for (int v = 0; v < 6; v++) begin
            lz_en = vecs[v].lz;
            sync_d0();
            load_word(vecs[v].word, a);
            chk("bcd_err", 16'(bcd_err), 16'(vecs[v].exp_err));
            next_slot();
            next_slot();
            chk("ready_before_boundary", 16'(load_ready), 16'h0);
            next_slot();
            chk("ready_after_boundary", 16'(load_ready), 16'h1);
            run_frame("vec_frame", vecs[v].exp_nibs);
        end

        // Display strobes off while scanning continues.
        lz_en = 1'b0;
        sync_d0();
        disp_en = 1'b0;
        next_slot();
        chk("dis_sel1", 16'(digit_sel), 16'hF);
        chk("dis_bcd1", 16'(bcd_out),   16'h0);
        next_slot();
        chk("dis_sel2", 16'(digit_sel), 16'hF);
        disp_en = 1'b1;
        next_slot();
        chk("dis_sel3", 16'(digit_sel),  16'(sel_tab[3]));
        chk("dis_fd3",  16'(frame_done), 16'h1);

        // Back-to-back loads: second waits for the boundary copy of the first.
        sync_d0();
        load_word(16'h1111, a);
        load_word(16'h2222, b);
        chk("b2b_accept_phase", 16'(b % 16), 16'd1);
        run_frame("b2b_ones", 16'h1111);
        run_frame("b2b_twos", 16'h2222);

        // Asynchronous reset with a pending word.
        sync_d0();
        load_word(16'h5A55, a);
        chk("pre_rst_err", 16'(bcd_err), 16'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_bcd",   16'(bcd_out),    16'hF);
        chk("async_sel",   16'(digit_sel),  16'hF);
        chk("async_fd",    16'(frame_done), 16'h0);
        chk("async_err",   16'(bcd_err),    16'h0);
        chk("async_ready", 16'(load_ready), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post_rst", 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
